res_station: RTL and testbench
==============================

RES_STATION -- requirements
Module: res_station

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 8, number of entries (power of two, >=4).
REQ-002 SHALL have parameter TAG_W, default 4, ROB tag width; tag 0 = "no tag / no instruction".
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rdy  in  1  global enable; low = freeze.
REQ-006 reset_from_rob_bus  in  1  mispredict flush.
REQ-007 dest_from_issuer  in  TAG_W  ROB tag of the incoming instruction; nonzero = issue this cycle.
REQ-008 op_from_issuer  in  6  opcode.
REQ-009 qj/qk_from_issuer  in  TAG_W each  pending producer tags.
REQ-010 vj/vk_from_issuer  in  32 each  operand values.
REQ-011 imm_from_issuer, pc_from_issuer  in  32 each.
REQ-012 dest/value_from_rss_bus  in  TAG_W/32  ALU result broadcast.
REQ-013 dest/value_from_lsb_bus  in  TAG_W/32  load result broadcast.
REQ-014 is_full  out  1  to the issuer's is_any_full term.
REQ-015 valid_to_alu  out  1  dispatch strobe.
REQ-016 dest/op/vj/vk/imm/pc_to_alu  out  TAG_W/6/32/32/32/32  dispatched instruction.

Function
REQ-017 Each entry SHALL hold busy, dest, op, qj, vj, qk, vk, imm, pc.
REQ-018 Accept: at the edge where dest_from_issuer!=0, the lowest-index non-busy entry SHALL be written and set busy.
REQ-019 Incoming qj/qk SHALL be snooped against both buses in the same cycle; on a match with a nonzero tag, q SHALL be stored as 0 and v as the bus value.
REQ-020 Wakeup: every busy entry with qj!=0 matching a nonzero bus dest SHALL load vj and clear qj next edge (same for qk). Both buses SHALL be checked independently.
REQ-021 An entry is ready when busy and qj==0 and qk==0, using registered state. An entry woken this cycle is eligible next cycle.
REQ-022 Dispatch: each edge, the lowest-index ready entry SHALL drive the *_to_alu registers, set valid_to_alu=1, and clear busy. With none ready, valid_to_alu=0 and the other outputs hold.
REQ-023 Latency without bypass: accepted at edge N, earliest valid_to_alu at edge N+1.
REQ-024 is_full SHALL be combinational, =1 when busy count >= RS_DEPTH-2. This covers the issuer's two-cycle registered issue pipeline, so an accept never arrives with no free entry.
REQ-025 An accept arriving with no free entry is a protocol violation. It SHALL be dropped and state unchanged.
REQ-026 Same-edge accept and dispatch SHALL both take effect. The freed entry is not reused until the next edge.
REQ-027 Flush: reset_from_rob_bus=1 SHALL clear all busy bits and valid_to_alu at that edge, overriding accept, wakeup and dispatch.
REQ-028 rdy=0: all registers SHALL hold and no accept/dispatch SHALL occur. Flush SHALL still apply.

Reset
REQ-029 rst_n low SHALL immediately clear all busy bits, valid_to_alu, and all *_to_alu outputs to 0. is_full SHALL read 0.

Configuration
REQ-030 Macro RS_BYPASS_EN, when defined: an incoming instruction that is ready after REQ-019 snooping, arriving when no stored entry is ready, SHALL dispatch at that edge without allocating an entry (latency 0 extra edges). Otherwise it behaves per REQ-018.
REQ-031 With RS_BYPASS_EN undefined, every instruction SHALL allocate an entry.

Structure
REQ-032 config.v SHALL hold RO_BUFFER_ID_TYPE, OP_TYPE, REG_TYPE, IMM_TYPE, RS_DEPTH default, and the null-tag constant.
REQ-033 Sub-module rs_selector (combinational find-first-set over busy / ready vectors, returning index plus found) SHALL be instantiated twice.

Verification
REQ-034 Issue dest=3, op=ADD, qj=qk=0, vj=5, vk=7 -> next edge valid_to_alu=1, dest_to_alu=3, vj=5, vk=7.
REQ-035 Issue dest=4, qj=2. Then rss bus dest=2, value=0x10 -> entry woken. The following edge dispatches dest=4 with vj=0x10.
REQ-036 Issue 6 never-ready entries (RS_DEPTH=8) -> is_full=1 after the 6th accept. Two more accepts are stored. No entry is lost.
REQ-037 Three entries ready simultaneously -> dispatched in index order 0,1,2 on consecutive edges.
REQ-038 Flush while 5 entries are busy and an accept is arriving -> next edge busy count 0, valid_to_alu=0, is_full=0.
REQ-039 With RS_BYPASS_EN defined, a ready issue into an empty station -> valid_to_alu at the accept edge and busy count stays 0. rst_n pulsed mid-run -> outputs 0 asynchronously.

Source files
------------

// File: rtl/res_station_pkg.sv
// Shared types and constants for the reservation station slice.
package res_station_pkg;
  localparam int RS_DEPTH_DEF = 8;
  localparam int TAG_W_DEF    = 4;
  localparam int OP_W         = 6;
  localparam int DATA_W       = 32;
  // ROB tag 0 means "no producer / no instruction"
  localparam int NULL_TAG     = 0;

  typedef logic [TAG_W_DEF-1:0] ro_buffer_id_t;
  typedef logic [OP_W-1:0]      op_t;
  typedef logic [DATA_W-1:0]    reg_t;
  typedef logic [DATA_W-1:0]    imm_t;
endpackage

// File: rtl/res_station_selector.sv
// rs_selector: combinational find-first-set, lowest index wins.
module rs_selector #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = ($clog2(N))'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/res_station.sv
// Reservation station: operand snooping, wakeup and in-order-by-index dispatch to the ALU.
// Optional same-edge bypass of ready instructions with `define RS_BYPASS_EN.
module res_station
  import res_station_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              reset_from_rob_bus,
  input  logic [TAG_W-1:0]  dest_from_issuer,
  input  logic [5:0]        op_from_issuer,
  input  logic [TAG_W-1:0]  qj_from_issuer,
  input  logic [TAG_W-1:0]  qk_from_issuer,
  input  logic [31:0]       vj_from_issuer,
  input  logic [31:0]       vk_from_issuer,
  input  logic [31:0]       imm_from_issuer,
  input  logic [31:0]       pc_from_issuer,
  input  logic [TAG_W-1:0]  dest_from_rss_bus,
  input  logic [31:0]       value_from_rss_bus,
  input  logic [TAG_W-1:0]  dest_from_lsb_bus,
  input  logic [31:0]       value_from_lsb_bus,
  output logic              is_full,
  output logic              valid_to_alu,
  output logic [TAG_W-1:0]  dest_to_alu,
  output logic [5:0]        op_to_alu,
  output logic [31:0]       vj_to_alu,
  output logic [31:0]       vk_to_alu,
  output logic [31:0]       imm_to_alu,
  output logic [31:0]       pc_to_alu
);
  localparam int IW = $clog2(RS_DEPTH);
  localparam int CW = IW + 1;
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(NULL_TAG);

  logic [RS_DEPTH-1:0]            busy, ready_vec, free_vec;
  logic [RS_DEPTH-1:0][TAG_W-1:0] dest_q, qj_q, qk_q;
  op_t  [RS_DEPTH-1:0]            op_q;
  reg_t [RS_DEPTH-1:0]            vj_q, vk_q;
  imm_t [RS_DEPTH-1:0]            imm_q, pc_q;

  logic [IW-1:0] free_idx, rdy_idx;
  logic          free_found, rdy_found;

  for (genvar i = 0; i < RS_DEPTH; i++) begin : g_ready
    assign ready_vec[i] = busy[i] && (qj_q[i] == NO_TAG) && (qk_q[i] == NO_TAG);
  end
  assign free_vec = ~busy;

  rs_selector #(.N(RS_DEPTH)) u_free_sel  (.vec(free_vec),  .idx(free_idx), .found(free_found));
  rs_selector #(.N(RS_DEPTH)) u_ready_sel (.vec(ready_vec), .idx(rdy_idx),  .found(rdy_found));

  // Incoming operands snoop both result buses so nothing broadcast this cycle is missed.
  logic             jr, jl, kr, kl;
  logic [TAG_W-1:0] in_qj, in_qk;
  logic [31:0]      in_vj, in_vk;
  assign jr    = (qj_from_issuer != NO_TAG) && (qj_from_issuer == dest_from_rss_bus);
  assign jl    = (qj_from_issuer != NO_TAG) && (qj_from_issuer == dest_from_lsb_bus);
  assign kr    = (qk_from_issuer != NO_TAG) && (qk_from_issuer == dest_from_rss_bus);
  assign kl    = (qk_from_issuer != NO_TAG) && (qk_from_issuer == dest_from_lsb_bus);
  assign in_qj = (jr || jl) ? NO_TAG : qj_from_issuer;
  assign in_qk = (kr || kl) ? NO_TAG : qk_from_issuer;
  assign in_vj = jr ? value_from_rss_bus : (jl ? value_from_lsb_bus : vj_from_issuer);
  assign in_vk = kr ? value_from_rss_bus : (kl ? value_from_lsb_bus : vk_from_issuer);

  logic accept, bypass, do_alloc;
  assign accept = dest_from_issuer != NO_TAG;
`ifdef RS_BYPASS_EN
  assign bypass = accept && (in_qj == NO_TAG) && (in_qk == NO_TAG) && !rdy_found;
`else
  assign bypass = 1'b0;
`endif
  // An accept with no free entry is dropped (issuer should have honoured is_full).
  assign do_alloc = accept && !bypass && free_found;

  logic [CW-1:0] busy_cnt;
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < RS_DEPTH; i++) busy_cnt = busy_cnt + CW'(busy[i]);
  end
  assign is_full = busy_cnt >= CW'(RS_DEPTH - 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= '0;
      dest_q       <= '0;
      op_q         <= '0;
      qj_q         <= '0;
      qk_q         <= '0;
      vj_q         <= '0;
      vk_q         <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      valid_to_alu <= 1'b0;
      dest_to_alu  <= '0;
      op_to_alu    <= '0;
      vj_to_alu    <= '0;
      vk_to_alu    <= '0;
      imm_to_alu   <= '0;
      pc_to_alu    <= '0;
    end else if (reset_from_rob_bus) begin
      busy         <= '0;
      valid_to_alu <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy[i] && qj_q[i] != NO_TAG) begin
          if (qj_q[i] == dest_from_rss_bus) begin
            vj_q[i] <= value_from_rss_bus;
            qj_q[i] <= NO_TAG;
          end else if (qj_q[i] == dest_from_lsb_bus) begin
            vj_q[i] <= value_from_lsb_bus;
            qj_q[i] <= NO_TAG;
          end
        end
        if (busy[i] && qk_q[i] != NO_TAG) begin
          if (qk_q[i] == dest_from_rss_bus) begin
            vk_q[i] <= value_from_rss_bus;
            qk_q[i] <= NO_TAG;
          end else if (qk_q[i] == dest_from_lsb_bus) begin
            vk_q[i] <= value_from_lsb_bus;
            qk_q[i] <= NO_TAG;
          end
        end
      end
      if (rdy_found) begin
        busy[rdy_idx] <= 1'b0;
        dest_to_alu   <= dest_q[rdy_idx];
        op_to_alu     <= op_q[rdy_idx];
        vj_to_alu     <= vj_q[rdy_idx];
        vk_to_alu     <= vk_q[rdy_idx];
        imm_to_alu    <= imm_q[rdy_idx];
        pc_to_alu     <= pc_q[rdy_idx];
      end else if (bypass) begin
        dest_to_alu   <= dest_from_issuer;
        op_to_alu     <= op_from_issuer;
        vj_to_alu     <= in_vj;
        vk_to_alu     <= in_vk;
        imm_to_alu    <= imm_from_issuer;
        pc_to_alu     <= pc_from_issuer;
      end
      valid_to_alu <= rdy_found || bypass;
      // Free slot comes from registered busy, so a slot dispatched this edge is never reused here.
      if (do_alloc) begin
        busy[free_idx]   <= 1'b1;
        dest_q[free_idx] <= dest_from_issuer;
        op_q[free_idx]   <= op_from_issuer;
        qj_q[free_idx]   <= in_qj;
        qk_q[free_idx]   <= in_qk;
        vj_q[free_idx]   <= in_vj;
        vk_q[free_idx]   <= in_vk;
        imm_q[free_idx]  <= imm_from_issuer;
        pc_q[free_idx]   <= pc_from_issuer;
      end
    end
  end
endmodule

// File: tb/tb_res_station.sv
// Self-checking bench for res_station: directed scenarios plus randomized run against a behavioural model.
module tb_res_station;
  localparam int DEPTH = 8;
`ifdef RS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst_n, rdy, reset_from_rob_bus;
  logic [3:0]  dest_from_issuer, qj_from_issuer, qk_from_issuer;
  logic [5:0]  op_from_issuer;
  logic [31:0] vj_from_issuer, vk_from_issuer, imm_from_issuer, pc_from_issuer;
  logic [3:0]  dest_from_rss_bus, dest_from_lsb_bus;
  logic [31:0] value_from_rss_bus, value_from_lsb_bus;
  logic        is_full, valid_to_alu;
  logic [3:0]  dest_to_alu;
  logic [5:0]  op_to_alu;
  logic [31:0] vj_to_alu, vk_to_alu, imm_to_alu, pc_to_alu;

  res_station #(.RS_DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .reset_from_rob_bus(reset_from_rob_bus),
    .dest_from_issuer(dest_from_issuer), .op_from_issuer(op_from_issuer),
    .qj_from_issuer(qj_from_issuer), .qk_from_issuer(qk_from_issuer),
    .vj_from_issuer(vj_from_issuer), .vk_from_issuer(vk_from_issuer),
    .imm_from_issuer(imm_from_issuer), .pc_from_issuer(pc_from_issuer),
    .dest_from_rss_bus(dest_from_rss_bus), .value_from_rss_bus(value_from_rss_bus),
    .dest_from_lsb_bus(dest_from_lsb_bus), .value_from_lsb_bus(value_from_lsb_bus),
    .is_full(is_full), .valid_to_alu(valid_to_alu), .dest_to_alu(dest_to_alu),
    .op_to_alu(op_to_alu), .vj_to_alu(vj_to_alu), .vk_to_alu(vk_to_alu),
    .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: a table of slots plus the ALU output registers.
  bit          m_busy [DEPTH];
  logic [3:0]  m_dest [DEPTH], m_qj [DEPTH], m_qk [DEPTH];
  logic [5:0]  m_op   [DEPTH];
  logic [31:0] m_vj [DEPTH], m_vk [DEPTH], m_imm [DEPTH], m_pc [DEPTH];
  logic        m_valid;
  logic [3:0]  m_odest;
  logic [5:0]  m_oop;
  logic [31:0] m_ovj, m_ovk, m_oimm, m_opc;

  task automatic idle();
    dest_from_issuer = 0; op_from_issuer = 0; qj_from_issuer = 0; qk_from_issuer = 0;
    vj_from_issuer = 0; vk_from_issuer = 0; imm_from_issuer = 0; pc_from_issuer = 0;
    dest_from_rss_bus = 0; value_from_rss_bus = 0; dest_from_lsb_bus = 0; value_from_lsb_bus = 0;
    reset_from_rob_bus = 0; rdy = 1;
  endtask

  task automatic issue(input logic [3:0] d, input logic [5:0] o, input logic [3:0] qj,
                       input logic [3:0] qk, input logic [31:0] vj, input logic [31:0] vk);
    dest_from_issuer = d; op_from_issuer = o; qj_from_issuer = qj; qk_from_issuer = qk;
    vj_from_issuer = vj; vk_from_issuer = vk;
    imm_from_issuer = 32'hA000 + 32'(d); pc_from_issuer = 32'h1000 + 32'(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    m_valid = 0; m_odest = 0; m_oop = 0; m_ovj = 0; m_ovk = 0; m_oimm = 0; m_opc = 0;
  endtask

  task automatic model_step();
    int r = -1;
    int f = -1;
    bit byp, acc;
    logic [3:0]  sqj, sqk;
    logic [31:0] svj, svk;
    if (reset_from_rob_bus) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
      m_valid = 0;
      return;
    end
    if (!rdy) return;
    for (int i = 0; i < DEPTH; i++) begin
      if (r < 0 && m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) r = i;
      if (f < 0 && !m_busy[i]) f = i;
    end
    sqj = qj_from_issuer; svj = vj_from_issuer; sqk = qk_from_issuer; svk = vk_from_issuer;
    if (sqj != 0 && sqj == dest_from_rss_bus) begin sqj = 0; svj = value_from_rss_bus; end
    else if (sqj != 0 && sqj == dest_from_lsb_bus) begin sqj = 0; svj = value_from_lsb_bus; end
    if (sqk != 0 && sqk == dest_from_rss_bus) begin sqk = 0; svk = value_from_rss_bus; end
    else if (sqk != 0 && sqk == dest_from_lsb_bus) begin sqk = 0; svk = value_from_lsb_bus; end
    acc = dest_from_issuer != 0;
    byp = BYP && acc && sqj == 0 && sqk == 0 && r < 0;
    m_valid = (r >= 0) || byp;
    if (r >= 0) begin
      m_odest = m_dest[r]; m_oop = m_op[r]; m_ovj = m_vj[r]; m_ovk = m_vk[r];
      m_oimm = m_imm[r]; m_opc = m_pc[r]; m_busy[r] = 0;
    end else if (byp) begin
      m_odest = dest_from_issuer; m_oop = op_from_issuer; m_ovj = svj; m_ovk = svk;
      m_oimm = imm_from_issuer; m_opc = pc_from_issuer;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && m_qj[i] != 0) begin
        if (m_qj[i] == dest_from_rss_bus) begin m_qj[i] = 0; m_vj[i] = value_from_rss_bus; end
        else if (m_qj[i] == dest_from_lsb_bus) begin m_qj[i] = 0; m_vj[i] = value_from_lsb_bus; end
      end
      if (m_busy[i] && m_qk[i] != 0) begin
        if (m_qk[i] == dest_from_rss_bus) begin m_qk[i] = 0; m_vk[i] = value_from_rss_bus; end
        else if (m_qk[i] == dest_from_lsb_bus) begin m_qk[i] = 0; m_vk[i] = value_from_lsb_bus; end
      end
    end
    if (acc && !byp && f >= 0) begin
      m_busy[f] = 1; m_dest[f] = dest_from_issuer; m_op[f] = op_from_issuer;
      m_qj[f] = sqj; m_qk[f] = sqk; m_vj[f] = svj; m_vk[f] = svk;
      m_imm[f] = imm_from_issuer; m_pc[f] = pc_from_issuer;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    #3;
    n_cmp++;
    if ({valid_to_alu, dest_to_alu, op_to_alu, vj_to_alu, vk_to_alu, imm_to_alu, pc_to_alu, is_full} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%0b d=%0h vj=%0h full=%0b, want all 0", valid_to_alu, dest_to_alu, vj_to_alu, is_full);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    issue(4'd3, 6'd1, 4'd0, 4'd0, 32'd5, 32'd7);
    tick();
    idle();
`ifndef RS_BYPASS_EN
    n_cmp++;
    if (valid_to_alu !== 1'b0) begin n_err++; $display("FAIL basic_latency: got valid=%0b want 0", valid_to_alu); end
    tick();
`endif
    n_cmp++;
    if ({valid_to_alu, dest_to_alu, op_to_alu, vj_to_alu, vk_to_alu, imm_to_alu, pc_to_alu} !==
        {1'b1, 4'd3, 6'd1, 32'd5, 32'd7, 32'hA003, 32'h1003}) begin
      n_err++;
      $display("FAIL basic_dispatch: got v=%0b d=%0h op=%0h vj=%0h vk=%0h imm=%0h pc=%0h want 1/3/1/5/7/a003/1003",
               valid_to_alu, dest_to_alu, op_to_alu, vj_to_alu, vk_to_alu, imm_to_alu, pc_to_alu);
    end
    tick();
    n_cmp++;
    if (valid_to_alu !== 1'b0) begin n_err++; $display("FAIL basic_idle: got valid=%0b want 0", valid_to_alu); end
  endtask

  task automatic test_wakeup();
    issue(4'd4, 6'd2, 4'd2, 4'd5, 32'd0, 32'd0);
    tick();
    idle();
    dest_from_rss_bus = 4'd2; value_from_rss_bus = 32'h10;
    dest_from_lsb_bus = 4'd5; value_from_lsb_bus = 32'h20;
    tick();
    idle();
    n_cmp++;
    if (valid_to_alu !== 1'b0) begin n_err++; $display("FAIL wake_not_early: got valid=%0b want 0", valid_to_alu); end
    tick();
    n_cmp++;
    if ({valid_to_alu, dest_to_alu, vj_to_alu, vk_to_alu} !== {1'b1, 4'd4, 32'h10, 32'h20}) begin
      n_err++;
      $display("FAIL wake_dispatch: got v=%0b d=%0h vj=%0h vk=%0h want 1/4/10/20", valid_to_alu, dest_to_alu, vj_to_alu, vk_to_alu);
    end
    // Operands resolved by snooping at issue time.
    issue(4'd7, 6'd3, 4'd9, 4'd6, 32'd0, 32'd0);
    dest_from_rss_bus = 4'd9; value_from_rss_bus = 32'hAB;
    dest_from_lsb_bus = 4'd6; value_from_lsb_bus = 32'hCD;
    tick();
    idle();
`ifndef RS_BYPASS_EN
    tick();
`endif
    n_cmp++;
    if ({valid_to_alu, dest_to_alu, vj_to_alu, vk_to_alu} !== {1'b1, 4'd7, 32'hAB, 32'hCD}) begin
      n_err++;
      $display("FAIL snoop_dispatch: got v=%0b d=%0h vj=%0h vk=%0h want 1/7/ab/cd", valid_to_alu, dest_to_alu, vj_to_alu, vk_to_alu);
    end
    tick();
  endtask

  task automatic test_full();
    for (int k = 1; k <= 8; k++) begin
      issue(4'(k), 6'd1, 4'd15, 4'd0, 32'(k), 32'd0);
      tick();
      n_cmp++;
      if ({is_full, valid_to_alu} !== {k >= 6, 1'b0}) begin
        n_err++;
        $display("FAIL full_fill%0d: got full=%0b v=%0b want full=%0b v=0", k, is_full, valid_to_alu, k >= 6);
      end
    end
    idle();
    dest_from_rss_bus = 4'd15; value_from_rss_bus = 32'h55;
    tick();
    idle();
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if ({valid_to_alu, dest_to_alu, vj_to_alu, is_full} !== {1'b1, 4'(k), 32'h55, (8 - k) >= 6}) begin
        n_err++;
        $display("FAIL order_drain%0d: got v=%0b d=%0h vj=%0h full=%0b want 1/%0h/55/%0b",
                 k, valid_to_alu, dest_to_alu, vj_to_alu, is_full, k, (8 - k) >= 6);
      end
    end
    tick();
    n_cmp++;
    if (valid_to_alu !== 1'b0) begin n_err++; $display("FAIL full_empty: got valid=%0b want 0", valid_to_alu); end
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 5; k++) begin
      issue(4'(k), 6'd1, 4'd14, 4'd0, 32'd0, 32'd0);
      tick();
    end
    issue(4'd9, 6'd1, 4'd0, 4'd0, 32'd1, 32'd1);
    reset_from_rob_bus = 1;
    tick();
    idle();
    n_cmp++;
    if ({valid_to_alu, is_full} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_clear: got v=%0b full=%0b want 0/0", valid_to_alu, is_full);
    end
    dest_from_rss_bus = 4'd14; value_from_rss_bus = 32'd1;
    tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (valid_to_alu !== 1'b0) begin n_err++; $display("FAIL flush_gone%0d: got valid=%0b want 0", k, valid_to_alu); end
    end
  endtask

  task automatic test_freeze();
    issue(4'd11, 6'd2, 4'd13, 4'd0, 32'd0, 32'd0);
    tick();
    idle();
    rdy = 0;
    dest_from_rss_bus = 4'd13; value_from_rss_bus = 32'h77;
    tick();
    tick();
    idle();
    tick();
    n_cmp++;
    if (valid_to_alu !== 1'b0) begin n_err++; $display("FAIL freeze_nowake: got valid=%0b want 0", valid_to_alu); end
    dest_from_rss_bus = 4'd13; value_from_rss_bus = 32'h78;
    tick();
    idle();
    tick();
    n_cmp++;
    if ({valid_to_alu, dest_to_alu, vj_to_alu} !== {1'b1, 4'd11, 32'h78}) begin
      n_err++;
      $display("FAIL freeze_resume: got v=%0b d=%0h vj=%0h want 1/b/78", valid_to_alu, dest_to_alu, vj_to_alu);
    end
    tick();
    rdy = 0;
    issue(4'd12, 6'd1, 4'd0, 4'd0, 32'd3, 32'd4);
    tick();
    tick();
    idle();
    tick();
    n_cmp++;
    if (valid_to_alu !== 1'b0) begin n_err++; $display("FAIL freeze_noaccept: got valid=%0b want 0", valid_to_alu); end
  endtask

  task automatic test_async_reset();
    for (int k = 1; k <= 6; k++) begin
      issue(4'(k), 6'd1, 4'd12, 4'd0, 32'd0, 32'd0);
      tick();
    end
    issue(4'd5, 6'd4, 4'd0, 4'd0, 32'h99, 32'd0);
    tick();
    idle();
`ifndef RS_BYPASS_EN
    tick();
`endif
    n_cmp++;
    if ({valid_to_alu, dest_to_alu, vj_to_alu, is_full} !== {1'b1, 4'd5, 32'h99, 1'b1}) begin
      n_err++;
      $display("FAIL arst_pre: got v=%0b d=%0h vj=%0h full=%0b want 1/5/99/1", valid_to_alu, dest_to_alu, vj_to_alu, is_full);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({valid_to_alu, dest_to_alu, op_to_alu, vj_to_alu, vk_to_alu, imm_to_alu, pc_to_alu, is_full} !== '0) begin
      n_err++;
      $display("FAIL arst_async: got v=%0b d=%0h vj=%0h full=%0b want all 0", valid_to_alu, dest_to_alu, vj_to_alu, is_full);
    end
    @(negedge clk);
    rst_n = 1;
    dest_from_rss_bus = 4'd12; value_from_rss_bus = 32'd1;
    tick();
    idle();
    tick();
    n_cmp++;
    if (valid_to_alu !== 1'b0) begin n_err++; $display("FAIL arst_cleared: got valid=%0b want 0", valid_to_alu); end
  endtask

  task automatic test_random();
    rst_n = 0;
    idle();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    tick();
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      reset_from_rob_bus = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 6) begin
        issue(4'($urandom_range(1, 15)), 6'($urandom),
              ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 7)),
              ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 7)),
              $urandom, $urandom);
      end
      if ($urandom_range(0, 9) < 6) begin
        dest_from_rss_bus = 4'($urandom_range(1, 7)); value_from_rss_bus = $urandom;
      end
      if ($urandom_range(0, 9) < 4) begin
        dest_from_lsb_bus = 4'($urandom_range(1, 7)); value_from_lsb_bus = $urandom;
      end
      model_step();
      tick();
      n_cmp++;
      if ({valid_to_alu, dest_to_alu, op_to_alu, vj_to_alu, vk_to_alu, imm_to_alu, pc_to_alu} !==
          {m_valid, m_odest, m_oop, m_ovj, m_ovk, m_oimm, m_opc}) begin
        n_err++;
        $display("FAIL rand_out cyc %0d: got v=%0b d=%0h op=%0h vj=%0h vk=%0h want v=%0b d=%0h op=%0h vj=%0h vk=%0h",
                 c, valid_to_alu, dest_to_alu, op_to_alu, vj_to_alu, vk_to_alu, m_valid, m_odest, m_oop, m_ovj, m_ovk);
      end
      n_cmp++;
      if (is_full !== (model_count() >= DEPTH - 2)) begin
        n_err++;
        $display("FAIL rand_full cyc %0d: got %0b want %0b", c, is_full, model_count() >= DEPTH - 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_flush();
    test_freeze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
